// File: rtl/dma_pkg.sv
// Shared types and status-word layout for the DMA dispatcher/controller link.
package dma_pkg;

    localparam int unsigned CMD_ADDR_W = 64;
    localparam int unsigned CMD_LEN_W  = 64;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] src;
        logic [CMD_ADDR_W-1:0] dst;
        logic [CMD_LEN_W-1:0]  len;
    } dma_cmd_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StActive = 2'd2,
        StMagic  = 2'd3
    } cmdq_state_e;

    localparam int unsigned CMDQ_STS_OCC_LSB   = 0;
    localparam int unsigned CMDQ_STS_FULL      = 7;
    localparam int unsigned CMDQ_STS_EMPTY     = 9;
    localparam int unsigned CMDQ_STS_OVF       = 10;
    localparam int unsigned CMDQ_STS_STATE_LSB = 11;
    localparam int unsigned CMDQ_STS_DROP_LSB  = 16;
    localparam int unsigned CMDQ_STS_DONE_LSB  = 32;

endpackage

// File: rtl/dma_cmd_fifo.sv
// Registered command FIFO; pointers reset asynchronously, storage is left unreset.
module dma_cmd_fifo
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  dma_cmd_t   wdata_i,
    output dma_cmd_t   rdata_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [6:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    dma_cmd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == 7'(DEPTH));
    assign empty_o = (count_q == 7'd0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + 7'(do_push) - 7'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dma_cmd_queue.sv
// Per-channel command queue: buffers CSR commands, issues them to the data mover,
// posts the magic-number write and raises a sticky completion interrupt.
module dma_cmd_queue
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LEN_W  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              new_cmd,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              sclr,
    input  logic              clear_irq,
    input  logic [ADDR_W-1:0] magic_addr,
    output logic              xfer_valid,
    input  logic              xfer_ready,
    output logic [ADDR_W-1:0] xfer_src,
    output logic [ADDR_W-1:0] xfer_dst,
    output logic [LEN_W-1:0]  xfer_len,
    input  logic              xfer_done,
    output logic              mn_wr_valid,
    output logic [ADDR_W-1:0] mn_wr_addr,
    input  logic              mn_wr_ready,
    output logic              busy,
    output logic              irq,
    output logic [63:0]       cmdq_status
);

    cmdq_state_e       state_q, state_d, next_st;
    logic              xfer_valid_q, xfer_valid_d;
    logic [ADDR_W-1:0] xfer_src_q, xfer_src_d, xfer_dst_q, xfer_dst_d;
    logic [LEN_W-1:0]  xfer_len_q, xfer_len_d;
    logic              mn_wr_valid_q, mn_wr_valid_d;
    logic [ADDR_W-1:0] mn_addr_q, mn_addr_d;
    logic              abort_q, abort_d;
    logic              irq_q, irq_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [31:0]       done_cnt_q, done_cnt_d;

    dma_cmd_t   cmd_in, head;
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty, done_evt;
    logic [6:0] fifo_count;

    dma_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (sclr),
        .wdata_i (cmd_in),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        cmd_in = '0;
        cmd_in.src[ADDR_W-1:0] = cmd_src;
        cmd_in.dst[ADDR_W-1:0] = cmd_dst;
        cmd_in.len[LEN_W-1:0]  = cmd_len;
        fifo_push = new_cmd && !sclr;
        fifo_pop  = (state_q == StIssue) && xfer_valid_q && xfer_ready && !sclr;
    end

    always_comb begin
        state_d       = state_q;
        xfer_valid_d  = xfer_valid_q;
        xfer_src_d    = xfer_src_q;
        xfer_dst_d    = xfer_dst_q;
        xfer_len_d    = xfer_len_q;
        mn_wr_valid_d = mn_wr_valid_q;
        mn_addr_d     = mn_addr_q;
        abort_d       = abort_q;
        done_evt      = 1'b0;
        next_st       = (!fifo_empty && !sclr) ? StIssue : StIdle;
        unique case (state_q)
            StIdle: if (!fifo_empty && !sclr) state_d = StIssue;
            StIssue: begin
                if (sclr) begin
                    xfer_valid_d = 1'b0;
                    state_d      = StIdle;
                end else if (!xfer_valid_q) begin
                    // Offer the head one cycle after entering ISSUE so xfer_* come from flops.
                    xfer_valid_d = 1'b1;
                    xfer_src_d   = head.src[ADDR_W-1:0];
                    xfer_dst_d   = head.dst[ADDR_W-1:0];
                    xfer_len_d   = head.len[LEN_W-1:0];
                end else if (xfer_ready) begin
                    xfer_valid_d = 1'b0;
                    mn_addr_d    = magic_addr;
                    state_d      = StActive;
                end
            end
            StActive: begin
                if (sclr) abort_d = 1'b1;
                if (xfer_done) begin
                    if (abort_q || sclr) begin
                        abort_d = 1'b0;
                        state_d = StIdle;
                    end else if (mn_addr_q != '0) begin
                        mn_wr_valid_d = 1'b1;
                        state_d       = StMagic;
                    end else begin
                        done_evt = 1'b1;
                        state_d  = next_st;
                    end
                end
            end
            StMagic: begin
                if (mn_wr_ready) begin
                    mn_wr_valid_d = 1'b0;
                    done_evt      = 1'b1;
                    state_d       = next_st;
                end
            end
            default: state_d = StIdle;
        endcase

        irq_d      = done_evt ? 1'b1 : (clear_irq ? 1'b0 : irq_q);
        done_cnt_d = done_cnt_q + 32'(done_evt);
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (new_cmd && !sclr && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (sclr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            done_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            xfer_valid_q  <= 1'b0;
            xfer_src_q    <= '0;
            xfer_dst_q    <= '0;
            xfer_len_q    <= '0;
            mn_wr_valid_q <= 1'b0;
            mn_addr_q     <= '0;
            abort_q       <= 1'b0;
            irq_q         <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
            done_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            xfer_valid_q  <= xfer_valid_d;
            xfer_src_q    <= xfer_src_d;
            xfer_dst_q    <= xfer_dst_d;
            xfer_len_q    <= xfer_len_d;
            mn_wr_valid_q <= mn_wr_valid_d;
            mn_addr_q     <= mn_addr_d;
            abort_q       <= abort_d;
            irq_q         <= irq_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
            done_cnt_q    <= done_cnt_d;
        end
    end

    assign xfer_valid  = xfer_valid_q;
    assign xfer_src    = xfer_src_q;
    assign xfer_dst    = xfer_dst_q;
    assign xfer_len    = xfer_len_q;
    assign mn_wr_valid = mn_wr_valid_q;
    assign mn_wr_addr  = mn_addr_q;
    assign irq         = irq_q;
    assign busy        = (state_q != StIdle) || !fifo_empty;

    always_comb begin
        cmdq_status = '0;
        cmdq_status[CMDQ_STS_OCC_LSB +: 7]    = fifo_count;
        cmdq_status[CMDQ_STS_FULL]            = fifo_full;
        cmdq_status[CMDQ_STS_EMPTY]           = fifo_empty;
        cmdq_status[CMDQ_STS_OVF]             = overflow_q;
        cmdq_status[CMDQ_STS_STATE_LSB +: 3]  = {1'b0, state_q};
        cmdq_status[CMDQ_STS_DROP_LSB +: 16]  = drop_cnt_q;
        cmdq_status[CMDQ_STS_DONE_LSB +: 32]  = done_cnt_q;
    end

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Bench for dma_cmd_queue: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a queue-based reference model.
module tb_dma_cmd_queue;

    localparam int unsigned DEPTH = 8;

    logic        clk, reset_n;
    logic        new_cmd, sclr, clear_irq;
    logic [63:0] cmd_src, cmd_dst, cmd_len, magic_addr;
    logic        xfer_valid, xfer_ready, xfer_done;
    logic [63:0] xfer_src, xfer_dst, xfer_len;
    logic        mn_wr_valid, mn_wr_ready;
    logic [63:0] mn_wr_addr;
    logic        busy, irq;
    logic [63:0] cmdq_status;

    int n_checks = 0;
    int n_errors = 0;

    dma_cmd_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (64),
        .LEN_W  (64)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .new_cmd     (new_cmd),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_len     (cmd_len),
        .sclr        (sclr),
        .clear_irq   (clear_irq),
        .magic_addr  (magic_addr),
        .xfer_valid  (xfer_valid),
        .xfer_ready  (xfer_ready),
        .xfer_src    (xfer_src),
        .xfer_dst    (xfer_dst),
        .xfer_len    (xfer_len),
        .xfer_done   (xfer_done),
        .mn_wr_valid (mn_wr_valid),
        .mn_wr_addr  (mn_wr_addr),
        .mn_wr_ready (mn_wr_ready),
        .busy        (busy),
        .irq         (irq),
        .cmdq_status (cmdq_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: phase 0=idle 1=issue 2=active 3=magic
    typedef struct {
        logic [63:0] s;
        logic [63:0] d;
        logic [63:0] l;
    } mcmd_t;

    mcmd_t       mq[$];
    int          mst = 0;
    bit          m_xv = 0, m_mnv = 0, m_abort = 0, m_irq = 0, m_ovf = 0;
    logic [63:0] m_src = '0, m_dst = '0, m_len = '0, m_mna = '0;
    int          m_drop = 0;
    logic [31:0] m_done = '0;

    initial begin
        bit    ne, fin, take;
        int    nxt;
        mcmd_t c;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                mst = 0; m_xv = 0; m_mnv = 0; m_abort = 0; m_irq = 0; m_ovf = 0;
                m_src = '0; m_dst = '0; m_len = '0; m_mna = '0; m_drop = 0; m_done = '0;
            end else begin
                ne   = (mq.size() != 0);
                fin  = 0;
                take = 0;
                nxt  = (ne && !sclr) ? 1 : 0;
                case (mst)
                    0: if (ne && !sclr) mst = 1;
                    1: begin
                        if (sclr) begin
                            m_xv = 0; mst = 0;
                        end else if (!m_xv && ne) begin
                            m_xv = 1; m_src = mq[0].s; m_dst = mq[0].d; m_len = mq[0].l;
                        end else if (m_xv && xfer_ready) begin
                            m_xv = 0; m_mna = magic_addr; mst = 2; take = 1;
                        end
                    end
                    2: begin
                        if (xfer_done && (m_abort || sclr)) begin
                            m_abort = 0; mst = 0;
                        end else if (xfer_done && m_mna != 0) begin
                            m_mnv = 1; mst = 3;
                        end else if (xfer_done) begin
                            fin = 1; mst = nxt;
                        end else if (sclr) begin
                            m_abort = 1;
                        end
                    end
                    default: if (mn_wr_ready) begin
                        m_mnv = 0; fin = 1; mst = nxt;
                    end
                endcase
                if (sclr) begin
                    mq.delete();
                end else begin
                    if (take) void'(mq.pop_front());
                    if (new_cmd) begin
                        if (mq.size() < DEPTH) begin
                            c.s = cmd_src; c.d = cmd_dst; c.l = cmd_len;
                            mq.push_back(c);
                        end else begin
                            m_ovf = 1;
                            if (m_drop < 65535) m_drop++;
                        end
                    end
                end
                if (sclr) begin
                    m_ovf = 0; m_drop = 0; m_done = '0;
                end else if (fin) begin
                    m_done = m_done + 32'd1;
                end
                if (fin) m_irq = 1;
                else if (clear_irq) m_irq = 0;
            end
        end
    end

    initial begin
        logic [63:0] exp_sts;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                exp_sts = {m_done, 16'(m_drop), 2'b00, 3'(mst), m_ovf, mq.size() == 0, 1'b0,
                           mq.size() == DEPTH, 7'(mq.size())};
                chk("m_xfer_valid", xfer_valid, m_xv);
                if (m_xv) begin
                    chk("m_xfer_src", xfer_src, m_src);
                    chk("m_xfer_dst", xfer_dst, m_dst);
                    chk("m_xfer_len", xfer_len, m_len);
                end
                chk("m_mn_wr_valid", mn_wr_valid, m_mnv);
                if (m_mnv) chk("m_mn_wr_addr", mn_wr_addr, m_mna);
                chk("m_busy", busy, (mst != 0) || (mq.size() != 0));
                chk("m_irq", irq, m_irq);
                chk("m_status", cmdq_status, exp_sts);
            end
        end
    end

    task automatic wait_xv(input int lim);
        int n = 0;
        while (!xfer_valid && n < lim) begin tick(); n++; end
        chk("wait_xfer_valid", xfer_valid, 1);
    endtask

    task automatic wait_mnv(input int lim);
        int n = 0;
        while (!mn_wr_valid && n < lim) begin tick(); n++; end
        chk("wait_mn_wr_valid", mn_wr_valid, 1);
    endtask

    task automatic push(input logic [63:0] s, input logic [63:0] d, input logic [63:0] l);
        new_cmd = 1; cmd_src = s; cmd_dst = d; cmd_len = l;
        tick();
        new_cmd = 0;
    endtask

    initial begin
        reset_n = 0; new_cmd = 0; sclr = 0; clear_irq = 0; xfer_ready = 0; xfer_done = 0;
        mn_wr_ready = 0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; magic_addr = '0;
        repeat (3) tick();
        reset_n = 1;
        chk("reset_status", cmdq_status, 64'h200);
        chk("reset_busy", busy, 0);
        chk("reset_irq", irq, 0);

        // Single command with magic write
        magic_addr = 64'h1000; xfer_ready = 1; mn_wr_ready = 1;
        push(64'hA000, 64'hB000, 64'h40);
        chk("t1_valid_e1", xfer_valid, 0);
        tick();
        chk("t1_valid_e2", xfer_valid, 0);
        tick();
        chk("t1_valid_e3", xfer_valid, 1);
        chk("t1_src", xfer_src, 64'hA000);
        tick();
        chk("t1_valid_drop", xfer_valid, 0);
        xfer_done = 1;
        tick();
        xfer_done = 0;
        chk("t1_mn_valid", mn_wr_valid, 1);
        chk("t1_mn_addr", mn_wr_addr, 64'h1000);
        tick();
        chk("t1_irq", irq, 1);
        chk("t1_done_cnt", cmdq_status[63:32], 1);
        chk("t1_empty", cmdq_status[9], 1);

        // Backpressure on both handshakes
        xfer_ready = 0; mn_wr_ready = 0; magic_addr = 64'h3000;
        push(64'hC0, 64'hD0, 64'h80);
        wait_xv(10);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_xfer_hold", xfer_valid && xfer_src == 64'hC0 && xfer_dst == 64'hD0 &&
                xfer_len == 64'h80, 1);
        end
        xfer_ready = 1;
        tick();
        xfer_ready = 0; xfer_done = 1;
        tick();
        xfer_done = 0;
        wait_mnv(5);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_mn_hold", mn_wr_valid && mn_wr_addr == 64'h3000, 1);
        end
        mn_wr_ready = 1;
        tick();
        chk("t2_mn_release", mn_wr_valid, 0);

        // Overflow: nine pushes into eight entries with the mover stalled
        sclr = 1; tick(); sclr = 0;
        magic_addr = 0;
        for (int i = 0; i < 9; i++) push(64'(i) << 8, 64'(i) << 12, 64'(i + 1));
        chk("t3_occ", cmdq_status[6:0], 8);
        chk("t3_full", cmdq_status[7], 1);
        chk("t3_ovf", cmdq_status[10], 1);
        chk("t3_drop", cmdq_status[31:16], 1);
        xfer_ready = 1;
        for (int k = 0; k < 8; k++) begin
            wait_xv(20);
            tick();
            xfer_done = 1;
            tick();
            xfer_done = 0;
        end
        tick();
        chk("t3_done_cnt", cmdq_status[63:32], 8);
        chk("t3_occ_end", cmdq_status[6:0], 0);

        // Full with simultaneous pop and push
        sclr = 1; xfer_ready = 0; tick(); sclr = 0;
        for (int i = 0; i < 8; i++) push(64'h100 + 64'(i), 64'h200, 64'h10);
        wait_xv(10);
        chk("t4_occ_full", cmdq_status[6:0], 8);
        xfer_ready = 1; new_cmd = 1; cmd_src = 64'h999;
        tick();
        xfer_ready = 0; new_cmd = 0;
        chk("t4_occ_after", cmdq_status[6:0], 8);
        chk("t4_no_ovf", cmdq_status[10], 0);
        sclr = 1; tick(); sclr = 0;
        xfer_done = 1; tick(); xfer_done = 0;

        // sclr while ACTIVE with three queued
        clear_irq = 1; tick(); clear_irq = 0;
        magic_addr = 64'h2000;
        for (int i = 0; i < 4; i++) push(64'h5000 + 64'(i), 64'h6000, 64'h20);
        wait_xv(10);
        xfer_ready = 1; tick(); xfer_ready = 0;
        chk("t5_occ3", cmdq_status[6:0], 3);
        chk("t5_active", cmdq_status[13:11], 2);
        sclr = 1; tick(); sclr = 0;
        chk("t5_flushed", cmdq_status[9], 1);
        xfer_done = 1; tick(); xfer_done = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_mn", mn_wr_valid, 0);
            chk("t5_no_irq", irq, 0);
            chk("t5_idle", cmdq_status[13:11], 0);
            chk("t5_not_busy", busy, 0);
            tick();
        end

        // irq set wins over clear_irq
        magic_addr = 0; xfer_ready = 1;
        push(64'h77, 64'h88, 64'h8);
        wait_xv(10);
        tick();
        xfer_done = 1; clear_irq = 1;
        tick();
        xfer_done = 0; clear_irq = 0;
        chk("t6_irq_set_wins", irq, 1);
        clear_irq = 1; tick(); clear_irq = 0;
        chk("t6_irq_clear", irq, 0);

        // Asynchronous reset in the middle of ACTIVE
        magic_addr = 64'h5000;
        push(64'h11, 64'h22, 64'h33);
        wait_xv(10);
        tick();
        chk("t7_active", cmdq_status[13:11], 2);
        #2 reset_n = 0;
        #1;
        chk("t7_rst_status", cmdq_status, 64'h200);
        chk("t7_rst_mn_addr", mn_wr_addr, 0);
        chk("t7_rst_xsrc", xfer_src, 0);
        chk("t7_rst_outs", {xfer_valid, mn_wr_valid, busy, irq}, 0);
        tick(); tick();
        reset_n = 1;

        // Random traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            new_cmd     = ($urandom_range(2) == 0);
            cmd_src     = {$urandom, $urandom};
            cmd_dst     = {$urandom, $urandom};
            cmd_len     = {32'h0, $urandom} | 64'h1;
            sclr        = ($urandom_range(99) == 0);
            clear_irq   = ($urandom_range(19) == 0);
            xfer_ready  = ($urandom_range(1) == 0);
            xfer_done   = ($urandom_range(5) == 0);
            mn_wr_ready = ($urandom_range(2) == 0);
            if ($urandom_range(49) == 0) begin
                case ($urandom_range(2))
                    0:       magic_addr = 64'h0;
                    1:       magic_addr = 64'h1000;
                    default: magic_addr = {$urandom, $urandom};
                endcase
            end
            tick();
        end
        new_cmd = 0; sclr = 0; clear_irq = 0; xfer_done = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
